// File: rtl/uart_rx_byte_pkg.sv
// Shared baud constants for the lakritz serial front end.
// The default bit period is derived from the board clock and line rate.
package uart_rx_byte_pkg;

    localparam int CLK_HZ = 12_000_000;
    localparam int BAUD   = 115_200;

    // Rounded to the nearest whole clock so the rate error stays below half a cycle per bit.
    function automatic int clks_per_bit(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

    localparam int DEF_CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer with asynchronous reset to a chosen level.
// Also intended for debouncing front ends on button inputs.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 serial byte receiver: one mid-bit sample per bit, holds the last good byte.
// Strobes one cycle for each good byte and for each framing error.
//
// state | meaning
// IDLE  | line idle, waiting for a falling edge on rx_s
// START | timing to the start-bit midpoint, rejecting glitches
// DATA  | sampling eight data bits, LSB first
// STOP  | sampling the stop bit
// BREAK | stop bit was low; wait for the line to return high
module uart_rx_byte
    import uart_rx_byte_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_START = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_STOP  = 3'd3;
    localparam logic [2:0] S_BREAK = 3'd4;

    logic             rx_s;
    logic [2:0]       state;
    logic [2:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shift;
    logic             cnt_mid;
    logic             cnt_last;
    logic             sample_bit;
    logic             valid_nxt;
    logic             ferr_nxt;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    assign cnt_mid  = (cnt == CNT_MID);
    assign cnt_last = (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_nxt = S_START;
            end
            S_START: begin
                if (cnt_mid) state_nxt = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (cnt_last && (idx == 3'd7)) state_nxt = S_STOP;
            end
            S_STOP: begin
                if (cnt_last) state_nxt = rx_s ? S_IDLE : S_BREAK;
            end
            S_BREAK: begin
                if (rx_s) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy       = (state != S_IDLE);
        sample_bit = (state == S_DATA) && cnt_last;
        valid_nxt  = (state == S_STOP) && cnt_last && rx_s;
        ferr_nxt   = (state == S_STOP) && cnt_last && !rx_s;
    end

    // The bit timer restarts on every state change and on each data-bit boundary.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= '0;
            idx       <= 3'd0;
            shift     <= 8'h00;
            data      <= 8'h00;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            valid     <= valid_nxt;
            frame_err <= ferr_nxt;
            if ((state_nxt != state) || cnt_last ||
                (state == S_IDLE) || (state == S_BREAK)) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
            if (state == S_START) begin
                idx <= 3'd0;
            end else if (sample_bit) begin
                shift[idx] <= rx_s;
                idx        <= idx + 3'd1;
            end
            if (valid_nxt) begin
                data <= shift;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Directed bench for uart_rx_byte at 16 clocks per bit.
// A negedge monitor logs every strobe; checks compare against hand-derived values.
module tb_uart_rx_byte;

    localparam int CPB   = 16;
    localparam int T_CLK = 10;
    localparam int T_BIT = CPB * T_CLK;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       busy;

    int         total = 0;
    int         bad   = 0;
    int         cyc   = 0;
    int         fe_cnt = 0;
    int         both_cnt = 0;
    logic [7:0] vq[$];
    int         vc[$];

    uart_rx_byte #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #(T_CLK / 2) clk = ~clk;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vq.push_back(data);
            vc.push_back(cyc);
        end
        if (frame_err === 1'b1) fe_cnt++;
        if ((valid === 1'b1) && (frame_err === 1'b1)) both_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int bit_t);
        rx = 1'b0;
        #(bit_t);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            #(bit_t);
        end
        rx = stop_bit;
        #(bit_t);
    endtask

    initial begin
        logic [7:0] b77;
        int         gap;
        b77 = 8'h77;
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_data", 32'(data), 32'h00);
        check_eq("rst_valid", 32'(valid), 32'd0);
        check_eq("rst_ferr", 32'(frame_err), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // short low glitch: START entered, aborted at the midpoint
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("glitch_busy_hi", 32'(busy), 32'd1);
        repeat (20) @(negedge clk);
        check_eq("glitch_busy_lo", 32'(busy), 32'd0);
        check_eq("glitch_no_valid", 32'(vq.size()), 32'd0);
        check_eq("glitch_data", 32'(data), 32'h00);

        send_frame(8'hA5, 1'b1, T_BIT);
        check_eq("a5_valid_cnt", 32'(vq.size()), 32'd1);
        check_eq("a5_pulse_data", 32'(vq[0]), 32'hA5);
        check_eq("a5_data", 32'(data), 32'hA5);
        check_eq("a5_no_ferr", 32'(fe_cnt), 32'd0);
        check_eq("a5_busy_lo", 32'(busy), 32'd0);

        // stop bit low, then line held in break for 40 bit times
        send_frame(8'h3C, 1'b0, T_BIT);
        #(40 * T_BIT);
        check_eq("brk_ferr_cnt", 32'(fe_cnt), 32'd1);
        check_eq("brk_busy_hi", 32'(busy), 32'd1);
        check_eq("brk_data", 32'(data), 32'hA5);
        check_eq("brk_no_valid", 32'(vq.size()), 32'd1);
        rx = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("brk_busy_lo", 32'(busy), 32'd0);
        check_eq("brk_ferr_once", 32'(fe_cnt), 32'd1);

        @(negedge clk);
        send_frame(8'h01, 1'b1, T_BIT);
        send_frame(8'hFE, 1'b1, T_BIT);
        repeat (4) @(negedge clk);
        check_eq("b2b_valid_cnt", 32'(vq.size()), 32'd3);
        check_eq("b2b_first", 32'(vq[1]), 32'h01);
        check_eq("b2b_second", 32'(vq[2]), 32'hFE);
        gap = vc[2] - vc[1];
        check_eq("b2b_spacing", 32'(gap), 32'(CPB * 10));
        check_eq("b2b_data", 32'(data), 32'hFE);

        // reset lands mid data bit 4, between clock edges
        @(negedge clk);
        rx = 1'b0;
        #(T_BIT);
        for (int i = 0; i < 4; i++) begin
            rx = b77[i];
            #(T_BIT);
        end
        rx = b77[4];
        #(T_BIT / 2 + 3);
        rst = 1'b1;
        #1;
        check_eq("arst_data", 32'(data), 32'h00);
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_valid", 32'(valid), 32'd0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_frame(8'h12, 1'b1, T_BIT);
        repeat (2) @(negedge clk);
        check_eq("arst_valid_cnt", 32'(vq.size()), 32'd4);
        check_eq("arst_after", 32'(vq[vq.size() - 1]), 32'h12);
        check_eq("arst_data_after", 32'(data), 32'h12);

        // transmitter about 3% fast, then 3% slow, phase deliberately off the clock grid
        send_frame(8'h5A, 1'b1, T_BIT - 5);
        repeat (20) @(negedge clk);
        check_eq("fast_valid_cnt", 32'(vq.size()), 32'd5);
        check_eq("fast_data", 32'(vq[vq.size() - 1]), 32'h5A);
        #3;
        send_frame(8'h5A, 1'b1, T_BIT + 5);
        repeat (20) @(negedge clk);
        check_eq("slow_valid_cnt", 32'(vq.size()), 32'd6);
        check_eq("slow_data", 32'(vq[vq.size() - 1]), 32'h5A);
        check_eq("tol_no_ferr", 32'(fe_cnt), 32'd1);
        check_eq("never_both", 32'(both_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
